// File: rtl/imem_loader_ctrl_if.sv
// Byte-stream input and instruction-memory write port of the imem loader.
// master = loader side (consumes rx bytes, drives the write port); slave = its environment.
interface imem_loader_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;

    modport master (
        input  rx_valid, rx_data,
        output imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        output rx_valid, rx_data,
        input  imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_ctrl.sv
// Loads the instruction memory from a byte stream: count byte, then LE words; write 1 cycle after 4th byte, no rx backpressure.
// Optional IMEM_LOADER_CHECKSUM_EN appends a mod-256 checksum byte checked before done.
module imem_loader_ctrl #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    imem_loader_ctrl_if.master bus,
    output logic              core_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   words_loaded_o
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, LOAD, WR, DONE, CHK} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, LOAD, WR, DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       asm_q, asm_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   wl_q, wl_d;
    logic              hold_q, hold_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic [ADDR_W:0]   wl_inc;
    logic              last_word;
    logic              timed;

    assign wl_inc    = wl_q + {{ADDR_W{1'b0}}, 1'b1};
    assign last_word = (wl_inc == n_q);
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign timed     = (state_q == HDR) || (state_q == LOAD) || (state_q == CHK);
`else
    assign timed     = (state_q == HDR) || (state_q == LOAD);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            asm_q   <= '0;
            n_q     <= '0;
            wl_q    <= '0;
            hold_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            tcnt_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            n_q     <= n_d;
            wl_q    <= wl_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            tcnt_q  <= tcnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        n_d     = n_q;
        wl_d    = wl_q;
        hold_d  = hold_q;
        err_d   = err_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        tcnt_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = HDR;
                    hold_d  = 1'b1;
                    err_d   = 1'b0;
                    wl_d    = '0;
                    bcnt_d  = '0;
                    asm_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            HDR: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data != 8'd0 && int'(bus.rx_data) <= DEPTH) begin
                        n_d     = bus.rx_data[ADDR_W:0];
                        state_d = LOAD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            LOAD: begin
                if (bus.rx_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d = sum_q + bus.rx_data;
`endif
                    if (bcnt_q == 2'd3) begin
                        // Output registers load here so the write pulse lines up with WR.
                        we_d    = 1'b1;
                        waddr_d = wl_q[ADDR_W-1:0];
                        wdata_d = {bus.rx_data, asm_q};
                        bcnt_d  = '0;
                        state_d = WR;
                    end else begin
                        asm_d[{bcnt_q, 3'b000} +: 8] = bus.rx_data;
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end
            end
            WR: begin
                wl_d = wl_inc;
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    // A byte landing in this cycle is already the checksum.
                    if (bus.rx_valid) begin
                        if (bus.rx_data == sum_q) begin
                            state_d = DONE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = CHK;
                    end
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = LOAD;
                    if (bus.rx_valid) begin
                        asm_d[7:0] = bus.rx_data;
                        bcnt_d     = 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d      = sum_q + bus.rx_data;
`endif
                    end
                end
            end
            DONE: begin
                hold_d  = 1'b0;
                state_d = IDLE;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == sum_q) begin
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (timed && !bus.rx_valid) begin
            if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                err_d   = 1'b1;
                state_d = IDLE;
                bcnt_d  = '0;
            end else begin
                tcnt_d = tcnt_q + {{(TW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.imem_we     = we_q;
    assign bus.imem_waddr  = waddr_q;
    assign bus.imem_wdata  = wdata_q;
    assign core_hold_o     = hold_q;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign err_o           = err_q;
    assign words_loaded_o  = wl_q;
endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Randomized and directed bench for imem_loader_ctrl against a session-level reference model.
module tb_imem_loader_ctrl;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int TMO    = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              core_hold, busy, done, err;
    logic [ADDR_W:0]   wl;

    imem_loader_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .bus            (bus),
        .core_hold_o    (core_hold),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .words_loaded_o (wl)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W+31:0] wr_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write-port and done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.imem_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_e = exp_q.pop_front();
                    check("waddr", 32'(bus.imem_waddr), 32'(wr_e[ADDR_W+31:32]));
                    check("wdata", bus.imem_wdata, wr_e[31:0]);
                end
            end
            if (done) begin
                done_cnt++;
                check("hold_at_done", 32'(core_hold), 32'd1);
            end
        end
    end

    task automatic put(input bit v, input logic [7:0] d, input bit s);
        bus.rx_valid = v;
        bus.rx_data  = d;
        start        = s;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        start        = 1'b0;
    endtask

    task automatic gap(input int maxgap);
        int g;
        g = (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
        for (int i = 0; i < g; i++) put(1'b0, 8'h00, ($urandom % 8) == 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 10 && busy; i++) put(1'b0, 8'h00, 1'b0);
        check("reach_idle", 32'(busy), 32'd0);
    endtask

    // Full session: start, count byte, data bytes (and checksum), then compare end state with the model.
    task automatic run_load(input string tag, input logic [7:0] nb, input logic [7:0] data[$],
                            input int maxgap, input bit good_chk);
        bit         valid;
        int         d0;
        logic [7:0] sum;
        logic [7:0] chk;
        bit         exp_ok;
        valid  = (nb >= 1) && (int'(nb) <= DEPTH);
        d0     = done_cnt;
        sum    = 8'h00;
        exp_ok = valid;
        if (valid) begin
            for (int w = 0; w < int'(nb); w++)
                exp_q.push_back({ADDR_W'(w), data[4*w+3], data[4*w+2], data[4*w+1], data[4*w]});
        end
        put(1'($urandom % 2), 8'($urandom), 1'b1);
        gap(maxgap);
        put(1'b1, nb, 1'b0);
        if (valid) begin
            for (int k = 0; k < 4*int'(nb); k++) begin
                gap(maxgap);
                put(1'b1, data[k], 1'b0);
                sum = sum + data[k];
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk = good_chk ? sum : sum + 8'd1;
            exp_ok = good_chk;
            gap(maxgap);
            put(1'b1, chk, 1'b0);
`else
            chk = sum;
`endif
        end else begin
            put(1'b1, 8'($urandom), 1'b0);
            put(1'b1, 8'($urandom), 1'b0);
        end
        wait_idle();
        check({tag, "_err"},   32'(err),       exp_ok ? 32'd0 : 32'd1);
        check({tag, "_hold"},  32'(core_hold), exp_ok ? 32'd0 : 32'd1);
        check({tag, "_words"}, 32'(wl),        valid ? 32'(nb) : 32'd0);
        check({tag, "_done"},  32'(done_cnt - d0), exp_ok ? 32'd1 : 32'd0);
        check({tag, "_wrq"},   32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic rand_data(input int nb, output logic [7:0] q[$]);
        q.delete();
        for (int i = 0; i < 4*nb; i++) q.push_back(8'($urandom));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] dq[$];
        logic [7:0] nb;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        #12;
        check("rst_hold",  32'(core_hold), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_words", 32'(wl), 32'd0);
        check("rst_we",    32'(bus.imem_we), 32'd0);
        check("rst_wdata", bus.imem_wdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic two-word load.
        dq = '{8'hB3, 8'h00, 8'h00, 8'h00, 8'h13, 8'h02, 8'h40, 8'h00};
        run_load("t1", 8'h02, dq, 2, 1'b1);

        // Illegal counts.
        dq.delete();
        run_load("t2_zero", 8'h00, dq, 1, 1'b1);
        run_load("t2_big",  8'h11, dq, 1, 1'b1);

        // Full depth, back-to-back bytes.
        rand_data(16, dq);
        run_load("t3_full", 8'd16, dq, 0, 1'b1);

        // Inter-byte timeout aborts with no write.
        put(1'b0, 8'h00, 1'b1);
        put(1'b1, 8'h03, 1'b0);
        put(1'b1, 8'hAA, 1'b0);
        put(1'b1, 8'hBB, 1'b0);
        for (int i = 0; i < TMO - 1; i++) put(1'b0, 8'h00, 1'b0);
        check("tmo_early_err",  32'(err),  32'd0);
        check("tmo_early_busy", 32'(busy), 32'd1);
        put(1'b0, 8'h00, 1'b0);
        check("tmo_err",  32'(err),       32'd1);
        check("tmo_busy", 32'(busy),      32'd0);
        check("tmo_hold", 32'(core_hold), 32'd1);
        rand_data(3, dq);
        run_load("t4_recover", 8'd3, dq, 3, 1'b1);

        // Reset in the middle of the second word.
        rand_data(2, dq);
        exp_q.push_back({ADDR_W'(0), dq[3], dq[2], dq[1], dq[0]});
        put(1'b0, 8'h00, 1'b1);
        put(1'b1, 8'h02, 1'b0);
        for (int k = 0; k < 6; k++) put(1'b1, dq[k], 1'b0);
        check("t5_pre_hold", 32'(core_hold), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_hold",  32'(core_hold), 32'd0);
        check("t5_busy",  32'(busy), 32'd0);
        check("t5_err",   32'(err), 32'd0);
        check("t5_words", 32'(wl), 32'd0);
        check("t5_we",    32'(bus.imem_we), 32'd0);
        check("t5_wdata", bus.imem_wdata, 32'd0);
        check("t5_one_write", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rand_data(2, dq);
        run_load("t5_after", 8'd2, dq, 1, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        dq = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load("t6_good", 8'd1, dq, 1, 1'b1);
        run_load("t6_bad",  8'd1, dq, 1, 1'b0);
        run_load("t6_good_b2b", 8'd1, dq, 0, 1'b1);
`endif

        // Random sessions.
        for (int s = 0; s < 20; s++) begin
            if ($urandom % 7 == 0) nb = ($urandom % 2) ? 8'h00 : 8'($urandom_range(255, 17));
            else                   nb = 8'($urandom_range(16, 1));
            rand_data((int'(nb) <= DEPTH) ? int'(nb) : 0, dq);
            run_load("rnd", nb, dq, 3, ($urandom % 4) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader_ctrl.md
Name: imem_loader_ctrl

Overview:
- Sequences programming of the 16-word instruction memory from an 8-bit byte stream, e.g. a UART RX front end.
- Receives a word count, assembles little-endian 32-bit words and drives the instruction memory write port with an auto-incrementing word address.
- Holds the single-cycle core stalled while a load is in progress.
- Sits between the serial receiver, the instruction memory write port and the core's hold input.

Parameters:
DEPTH, 16, number of 32-bit words in instruction memory
ADDR_W, 4, word-address width (log2 DEPTH)
TIMEOUT_CYC, 1000000, max idle clock cycles between bytes during a load before abort

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a load session
rx_valid  in  1  rx_data valid this cycle; every byte is accepted, no backpressure
rx_data  in  8  received byte
imem_we  out  1  instruction memory write enable, one-cycle pulse per word
imem_waddr  out  ADDR_W  word index to write; byte address = index*4
imem_wdata  out  32  assembled word, {b3,b2,b1,b0}
core_hold  out  1  stalls the core's PC/fetch while high
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on successful completion
err  out  1  sticky error flag; cleared by the next accepted start or by rst
words_loaded  out  ADDR_W+1  count of words written in the current or last session

Behaviour:
- Reset values: all outputs 0. State is IDLE. All counters and the assembly register are 0.
- States: IDLE, HDR, LOAD, WR, DONE (plus CHK, see Optional Feature).
- IDLE:
  - start=1 moves to HDR and sets core_hold=1, err=0, words_loaded=0, word index=0.
  - rx_valid is ignored in IDLE.
  - If start and rx_valid occur in the same cycle, start is taken and the byte is discarded.
- HDR: the first accepted byte is the word count N.
  - If 1<=N<=DEPTH: latch N and go to LOAD.
  - Otherwise: set err=1 and go to IDLE.
- LOAD:
  - A 2-bit byte counter places each byte: byte k goes to bits [8k+7:8k].
  - On the 4th byte, go to WR and clear the byte counter.
- WR: lasts exactly one cycle.
  - imem_we=1, imem_waddr=word index, imem_wdata=assembled word.
  - The 4th byte arrives on cycle T; the write pulse appears on cycle T+1.
  - words_loaded and the word index increment at the end of WR.
  - If this was word N, go to DONE; otherwise go to LOAD.
  - An rx_valid byte arriving during WR is accepted as byte 0 of the next word. No byte is ever dropped while busy.
- DONE: lasts one cycle.
  - done=1 and core_hold is cleared at the end of the cycle, then go to IDLE.
- imem_waddr and imem_wdata hold their last values when imem_we=0.
- start while busy is ignored.
- Timeout:
  - In HDR and LOAD, a cycle counter resets on every accepted byte.
  - On reaching TIMEOUT_CYC: set err=1, go to IDLE, discard any partial word.
- Error policy:
  - core_hold is cleared only by a successful DONE or by rst.
  - After any error, core_hold stays 1, so a partially written program never runs.
- rst mid-session:
  - Immediate return to reset values, including core_hold=0.
  - Words already written stay in memory; the partial word is lost.
- Arithmetic: the word index never exceeds N-1 <= DEPTH-1, so no address wrap-around is possible.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After word N, WR goes to CHK instead of DONE.
  - CHK waits for one byte equal to the mod-256 sum of all 4N data bytes.
  - Match: go to DONE.
  - Mismatch: err=1, go to IDLE, core_hold stays 1.
  - Timeout rules apply in CHK.
- Not defined: the CHK state and the sum accumulator are absent; WR goes directly to DONE after word N.

Test Plan:
1. start, then bytes 02, B3,00,00,00, 13,02,40,00 -> imem_we pulses with (0, 0x000000B3) then (1, 0x00400213); done pulses one cycle; core_hold=0; words_loaded=2; err=0.
2. start, then byte 00 -> err=1; state IDLE; core_hold=1; imem_we never asserted. Repeat with byte 0x11 (17 > DEPTH) -> same response.
3. Back-to-back bytes with rx_valid=1 every cycle, N=16 (64 data bytes) -> 16 writes to addresses 0..15 in order; no byte lost; done pulses after the write to address 15.
4. TIMEOUT_CYC=20: start, then 03, AA, BB and no further bytes -> err=1 on the 20th idle cycle; no write occurs; core_hold=1. A new start followed by a valid load -> err cleared, core_hold=0 at done.
5. Assert rst after 6 data bytes of an N=2 load -> all outputs 0 asynchronously; exactly one write (address 0) occurred; a subsequent full load succeeds.
6. With IMEM_LOADER_CHECKSUM_EN: N=1, bytes 01,02,03,04, checksum 0A -> done=1. Checksum 0B -> err=1, no done pulse, core_hold=1.
